// File: rtl/plab2_proc_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds function codes, FSM state encodings, width default and decode helpers.
// No logic of its own; imported by the control and datapath files.
package plab2_proc_muldiv_iter_pkg;

  localparam int P_NBITS = 32;

  // Down-counter start value: 32 iterations, one result bit per cycle
  localparam logic [4:0] CNT_INIT = 5'd31;

  typedef enum logic [2:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reserved encodings (5-7) fold onto MUL
  function automatic fn_e decode_fn(input logic [2:0] fn);
    case (fn)
      3'd1:    return FN_DIV;
      3'd2:    return FN_DIVU;
      3'd3:    return FN_REM;
      3'd4:    return FN_REMU;
      default: return FN_MUL;
    endcase
  endfunction

  function automatic logic fn_is_signed(input fn_e fn);
    return (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  function automatic logic fn_is_div(input fn_e fn);
    return (fn == FN_DIV) || (fn == FN_DIVU) || (fn == FN_REM) || (fn == FN_REMU);
  endfunction

endpackage

// File: rtl/plab2_proc_muldiv_iter_ctrl.sv
// Control FSM and iteration counter for the iterative multiply/divide unit.
// Latency: accept at T, CALC from T+1, DONE at T+33 (or earlier on early_done).
// Backpressure: holds DONE (resp_val=1, req_rdy=0) until resp_rdy; IDLE next cycle.
module plab2_proc_muldiv_iter_ctrl
  import plab2_proc_muldiv_iter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_val,
  input  logic resp_rdy,
  input  logic early_done,
  output logic req_rdy,
  output logic resp_val,
  output logic accept,
  output logic calc_en,
  output logic calc_last
);

  state_e     state;
  logic [4:0] cnt;

  // Handshake and iteration qualifiers derived from registered state
  assign accept    = req_val && req_rdy;
  assign calc_en   = (state == ST_CALC);
  assign calc_last = calc_en && ((cnt == 5'd0) || early_done);

  // FSM with registered ready/valid; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 5'd0;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_CALC;
            cnt     <= CNT_INIT;
            req_rdy <= 1'b0;
          end
        end
        ST_CALC: begin
          if (calc_last) begin
            state    <= ST_DONE;
            cnt      <= 5'd0;
            resp_val <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DONE: begin
          // req_rdy stays low in the handshake cycle; accept resumes next cycle
          if (resp_rdy) begin
            state    <= ST_IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= 5'd0;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/plab2_proc_muldiv_iter.sv
// Iterative MUL/DIV/DIVU/REM/REMU unit: shift-add multiply, restoring divide.
// Latency: fixed 33 cycles accept-to-resp_val; PLAB2_PROC_MULDIV_EARLY_EXIT_EN shortens MUL.
// Backpressure: one op in flight; result/domain held until resp_val && resp_rdy.
module plab2_proc_muldiv_iter
  import plab2_proc_muldiv_iter_pkg::*;
#(
  parameter int p_nbits = P_NBITS
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2:0]         req_fn,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  input  logic               req_domain,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result,
  output logic               resp_domain
);

  logic accept;
  logic calc_en;
  logic calc_last;
  logic early_done;

  // For MUL: a_q = multiplicand (shifts left), b_q = multiplier (shifts right).
  // For divides: a_q = dividend magnitude shifting out / quotient shifting in,
  // b_q = divisor magnitude, rem_q = partial remainder.
  fn_e               fn_q;
  logic [p_nbits-1:0] a_q;
  logic [p_nbits-1:0] b_q;
  logic [p_nbits-1:0] acc_q;
  logic [p_nbits-1:0] rem_q;
  logic               a_neg_q;
  logic               b_neg_q;

  fn_e                req_op;
  logic               req_a_neg;
  logic               req_b_neg;

  logic [p_nbits-1:0] acc_nxt;
  logic [p_nbits:0]   trial;
  logic               trial_ge;
  logic [p_nbits-1:0] rem_nxt;
  logic [p_nbits-1:0] quo_nxt;
  logic [p_nbits-1:0] quo_fix;
  logic [p_nbits-1:0] rem_fix;
  logic [p_nbits-1:0] result_nxt;

  plab2_proc_muldiv_iter_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .resp_rdy   (resp_rdy),
    .early_done (early_done),
    .req_rdy    (req_rdy),
    .resp_val   (resp_val),
    .accept     (accept),
    .calc_en    (calc_en),
    .calc_last  (calc_last)
  );

`ifdef PLAB2_PROC_MULDIV_EARLY_EXIT_EN
  // MUL finishes once this iteration leaves no multiplier bits to consume
  assign early_done = (fn_q == FN_MUL) && (b_q[p_nbits-1:1] == '0);
`else
  assign early_done = 1'b0;
`endif

  // Request decode: signed divides work on magnitudes, signs kept aside
  always_comb begin
    req_op    = decode_fn(req_fn);
    req_a_neg = fn_is_signed(req_op) && req_a[p_nbits-1];
    req_b_neg = fn_is_signed(req_op) && req_b[p_nbits-1];
  end

  // One iteration step for both the multiply and the restoring divide
  always_comb begin
    acc_nxt  = acc_q + (b_q[0] ? a_q : '0);
    trial    = {rem_q, a_q[p_nbits-1]};
    trial_ge = (trial >= {1'b0, b_q});
    rem_nxt  = trial_ge ? (trial[p_nbits-1:0] - b_q) : trial[p_nbits-1:0];
    quo_nxt  = {a_q[p_nbits-2:0], trial_ge};
  end

  // Sign correction and result select; divide-by-zero keeps all-ones quotient
  always_comb begin
    if (b_q == '0)
      quo_fix = '1;
    else if (a_neg_q ^ b_neg_q)
      quo_fix = -quo_nxt;
    else
      quo_fix = quo_nxt;
    rem_fix = a_neg_q ? -rem_nxt : rem_nxt;
    case (fn_q)
      FN_DIV, FN_DIVU: result_nxt = quo_fix;
      FN_REM, FN_REMU: result_nxt = rem_fix;
      default:         result_nxt = acc_nxt;
    endcase
  end

  // Operand capture on accept, iteration in CALC, result capture on last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fn_q        <= FN_MUL;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      resp_result <= '0;
      resp_domain <= 1'b0;
    end else if (accept) begin
      fn_q        <= req_op;
      a_q         <= req_a_neg ? -req_a : req_a;
      b_q         <= req_b_neg ? -req_b : req_b;
      acc_q       <= '0;
      rem_q       <= '0;
      a_neg_q     <= req_a_neg;
      b_neg_q     <= req_b_neg;
      resp_domain <= req_domain;
    end else if (calc_en) begin
      if (fn_is_div(fn_q)) begin
        a_q   <= quo_nxt;
        rem_q <= rem_nxt;
      end else begin
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        acc_q <= acc_nxt;
      end
      if (calc_last)
        resp_result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_plab2_proc_muldiv_iter.sv
// Self-checking bench: directed corner cases plus random ops against an arithmetic model.
// Checks latency, result, domain, DONE hold under backpressure and mid-op reset abort.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_plab2_proc_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_fn;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_domain;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_result;
  logic        resp_domain;

  int n_chk  = 0;
  int n_fail = 0;

  plab2_proc_muldiv_iter #(.p_nbits(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_fn      (req_fn),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_domain  (req_domain),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_result (resp_result),
    .resp_domain (resp_domain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference arithmetic, RISC-V M semantics
  function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      3'd1:    return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      3'd2:    return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd3:    return (b == 0) ? a : 32'(sa % sb);
      3'd4:    return (b == 0) ? a : a % b;
      default: return 32'(a * b);
    endcase
  endfunction

  // Cycles from the accept edge to the first edge that shows resp_val
  function automatic int ref_latency(input logic [2:0] fn, input logic [31:0] b);
`ifdef PLAB2_PROC_MULDIV_EARLY_EXIT_EN
    int len;
    if (fn >= 3'd1 && fn <= 3'd4) return 33;
    len = 0;
    for (int i = 0; i < 32; i++)
      if (b[i]) len = i + 1;
    return 1 + ((len < 1) ? 1 : len);
`else
    return 33 + 0 * int'(fn) + 0 * int'(b[0]);
`endif
  endfunction

  // Issue one op, wait for the result, check it, optionally stall, then drain
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic dom, input int stall);
    int          lat;
    logic [31:0] exp_res;
    exp_res = ref_result(fn, a, b);
    chk("req_rdy_idle", 32'(req_rdy), 32'd1);
    req_val    = 1'b1;
    req_fn     = fn;
    req_a      = a;
    req_b      = b;
    req_domain = dom;
    @(posedge clk); #1;
    lat = 1;
    // garbage on the request bus while busy must be ignored
    while (!resp_val && lat < 60) begin
      req_val    = 1'($urandom_range(0, 1));
      req_fn     = 3'($urandom);
      req_a      = $urandom;
      req_b      = $urandom;
      req_domain = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    req_val = 1'b0;
    if (!resp_val) begin
      chk("resp_timeout", 32'(resp_val), 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(ref_latency(fn, b)));
    chk("result", resp_result, exp_res);
    chk("domain", 32'(resp_domain), 32'(dom));
    chk("req_rdy_done", 32'(req_rdy), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_val", 32'(resp_val), 32'd1);
      chk("hold_result", resp_result, exp_res);
      chk("hold_domain", 32'(resp_domain), 32'(dom));
      chk("hold_req_rdy", 32'(req_rdy), 32'd0);
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    chk("drain_val", 32'(resp_val), 32'd0);
    chk("drain_req_rdy", 32'(req_rdy), 32'd1);
  endtask

  logic [2:0]  d_fn [10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd2, 3'd4, 3'd1, 3'd3, 3'd6, 3'd3};
  logic [31:0] d_a  [10] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd5, 32'd5,
                             32'h80000000, 32'h80000000, 32'h00012345, 32'hFFFFFF00};
  logic [31:0] d_b  [10] = '{32'hFFFFFFFD, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000100, 32'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r_fn;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          stray;

    reset      = 1'b1;
    req_val    = 1'b0;
    req_fn     = 3'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    req_domain = 1'b0;
    resp_rdy   = 1'b0;
    #12;
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_domain", 32'(resp_domain), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // directed corner cases; one with a 10-cycle DONE stall
    for (int i = 0; i < 10; i++)
      run_op(d_fn[i], d_a[i], d_b[i], 1'(i), (i == 0) ? 10 : 0);
    run_op(3'd0, 32'd9, 32'd1, 1'b1, 0);
    run_op(3'd0, 32'd123, 32'd0, 1'b0, 2);

    // random ops over all fn codes including reserved ones
    for (int i = 0; i < 24; i++) begin
      r_fn = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 4))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = -32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      run_op(r_fn, r_a, r_b, 1'($urandom), $urandom_range(0, 3));
    end

    // reset ten cycles into a MUL: must abort with no response
    req_val    = 1'b1;
    req_fn     = 3'd0;
    req_a      = 32'd7;
    req_b      = 32'd5;
    req_domain = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_req_rdy", 32'(req_rdy), 32'd1);
    chk("abort_resp_val", 32'(resp_val), 32'd0);
    chk("abort_result", resp_result, 32'd0);
    chk("abort_domain", 32'(resp_domain), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_val) stray++;
    end
    chk("abort_no_resp", 32'(stray), 32'd0);
    chk("abort_idle", 32'(req_rdy), 32'd1);

    // unit recovers after abort
    run_op(3'd1, 32'hFFFFFFF9, 32'd2, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
